// File: rtl/corr_applier.sv
// corr_applier: applies buffered per-baseline offset corrections to X-engine
// cross-products, which carry offset-binary real parts, to recover true signed
// visibilities. It forwards end-of-frame markers and counts completed frames.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   corr_vld/re/im/last   correction word set from the tracker (FIFO push)
//   din_vld/re/im         raw product set from the X-engine (FIFO pop)
//   dout_vld/re/im/last   corrected product set, 2 cycles after din_vld
//   frame_ctr             completed frame count (wraps)
//   err_ovf, err_unf      sticky FIFO overflow / underflow flags
//
// Lane packing is {xx,xy,yx,yy}. xx occupies the MSBs, so lane index 3 is xx.
module corr_applier #(
  parameter int BITWIDTH        = 4,
  parameter int CORR_WIDTH      = 16,
  parameter int ACC_WIDTH       = 32,
  parameter int RE_OFFSET       = 0,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       corr_vld,
  input  logic [4*CORR_WIDTH-1:0]    corr_re,
  input  logic [4*CORR_WIDTH-1:0]    corr_im,
  input  logic                       corr_last,
  input  logic                       din_vld,
  input  logic [4*ACC_WIDTH-1:0]     din_re,
  input  logic [4*ACC_WIDTH-1:0]     din_im,
  output logic                       dout_vld,
  output logic [4*(ACC_WIDTH+1)-1:0] dout_re,
  output logic [4*(ACC_WIDTH+1)-1:0] dout_im,
  output logic                       dout_last,
  output logic [15:0]                frame_ctr,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int OW    = ACC_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW4   = 4 * CORR_WIDTH;
  localparam int AW4   = 4 * ACC_WIDTH;

  logic [CW4-1:0]             mem_re [DEPTH];
  logic [CW4-1:0]             mem_im [DEPTH];
  logic                       mem_last [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       full, empty, do_push, do_pop;

  assign full  = (count == (FIFO_DEPTH_BITS+1)'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO still accepts a push when a pop frees the head in the same cycle.
  assign do_push = corr_vld && (!full || din_vld);
  // A pop against an empty FIFO is not served by a same-cycle push.
  assign do_pop  = din_vld && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_re[wr_ptr]   <= corr_re;
      mem_im[wr_ptr]   <= corr_im;
      mem_last[wr_ptr] <= corr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (corr_vld && full && !din_vld) err_ovf <= 1'b1;
      if (din_vld && empty)             err_unf <= 1'b1;
    end
  end

  // Stage 1: capture the product set and the popped correction.
  // An unserved pop carries a zero correction and no frame marker.
  logic           s1_vld, s1_last;
  logic [AW4-1:0] s1_din_re, s1_din_im;
  logic [CW4-1:0] s1_corr_re, s1_corr_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_din_re  <= '0;
      s1_din_im  <= '0;
      s1_corr_re <= '0;
      s1_corr_im <= '0;
    end else begin
      s1_vld <= din_vld;
      if (din_vld) begin
        s1_din_re  <= din_re;
        s1_din_im  <= din_im;
        s1_corr_re <= do_pop ? mem_re[rd_ptr]   : '0;
        s1_corr_im <= do_pop ? mem_im[rd_ptr]   : '0;
        s1_last    <= do_pop ? mem_last[rd_ptr] : 1'b0;
      end
    end
  end

  // Per-lane correction, done at OW bits so every result wraps modulo 2^OW.
  logic [4*OW-1:0] res_re, res_im;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [OW-1:0] d_re, d_im, c_re, c_im;
    assign d_re = OW'($signed(s1_din_re[k*ACC_WIDTH +: ACC_WIDTH]));
    assign d_im = OW'($signed(s1_din_im[k*ACC_WIDTH +: ACC_WIDTH]));
    assign c_re = OW'($signed(s1_corr_re[k*CORR_WIDTH +: CORR_WIDTH]));
    assign c_im = OW'($signed(s1_corr_im[k*CORR_WIDTH +: CORR_WIDTH]));
    assign res_re[k*OW +: OW] = d_re - (c_re <<< (BITWIDTH-1)) + OW'(RE_OFFSET);
    assign res_im[k*OW +: OW] = d_im - (c_im <<< (BITWIDTH-1));
  end

  // Stage 2: the data outputs only change on a valid set, so they hold between sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld  <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
      dout_last <= 1'b0;
      frame_ctr <= '0;
    end else begin
      dout_vld <= s1_vld;
      if (s1_vld) begin
        dout_re   <= res_re;
        dout_im   <= res_im;
        dout_last <= s1_last;
      end
      if (dout_vld && dout_last) frame_ctr <= frame_ctr + 1'b1;
    end
  end

endmodule
